// File: rtl/lcd_bitmap_buffer.sv
// Double-buffered 1-bpp bitmap store: packs a host byte stream into words, fills the back bank and
// swaps banks at LCD vsync. Optional LCD_BB_TESTPAT_EN shows a checkerboard instead of blank before the first swap.
module lcd_bitmap_buffer #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int SWAP_ON_VSY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_sof,
  input  logic              lcd_vsy,
  input  logic [ADDR_W-1:0] ram_ab,
  output logic [DATA_W-1:0] ram_db,
  output logic              frame_done,
  output logic              err_sync
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BPW   = DATA_W / 8;
  localparam int KW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [KW-1:0]     K_LAST = KW'(BPW - 1);
  localparam logic [ADDR_W-1:0] A_LAST = '1;

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP, SWAP} state_t;

  state_t              state_reg;
  logic                in_ready_reg;
  logic                frame_done_reg;
  logic                err_sync_reg;
  logic                disp_bank_reg;
  logic                disp_valid_reg;
  logic                vsy_q;
  logic [KW-1:0]       k_reg;
  logic [ADDR_W-1:0]   w_addr_reg;
  logic [DATA_W-1:0]   word_reg;

  logic [DATA_W-1:0]   mem [0:2*DEPTH-1];
  logic [DATA_W-1:0]   rd_data_reg;
  logic [DATA_W-1:0]   blank_reg;
  logic [DATA_W-1:0]   blank_next;
  logic                rd_valid_reg;

  logic                store;
  logic                commit;
  logic                vsy_edge;
  logic [KW-1:0]       k_eff;
  logic [ADDR_W-1:0]   a_eff;
  logic [DATA_W-1:0]   wr_word;

  // An in_sof byte always lands at word 0, byte 0, whether starting or restarting an image.
  always_comb begin
    store    = in_valid & in_ready_reg & (in_sof | (state_reg == FILL));
    k_eff    = in_sof ? '0 : k_reg;
    a_eff    = in_sof ? '0 : w_addr_reg;
    commit   = store & (k_eff == K_LAST);
    vsy_edge = vsy_q & ~lcd_vsy;
  end

  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_pack
      localparam logic [KW-1:0] KI = KW'(gi);
      assign wr_word[8*gi +: 8] = (k_eff == KI) ? in_data : word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b1;
      frame_done_reg <= 1'b0;
      err_sync_reg   <= 1'b0;
      disp_bank_reg  <= 1'b0;
      disp_valid_reg <= 1'b0;
      vsy_q          <= 1'b1;
      k_reg          <= '0;
      w_addr_reg     <= '0;
      word_reg       <= '0;
    end else begin
      vsy_q          <= lcd_vsy;
      frame_done_reg <= 1'b0;
      err_sync_reg   <= 1'b0;
      if (store) begin
        word_reg     <= wr_word;
        err_sync_reg <= in_sof & (state_reg == FILL);
        if (commit) begin
          k_reg      <= '0;
          w_addr_reg <= a_eff + 1'b1;
          if (a_eff == A_LAST) begin
            state_reg    <= WAIT_SWAP;
            in_ready_reg <= 1'b0;
          end else begin
            state_reg <= FILL;
          end
        end else begin
          k_reg      <= k_eff + 1'b1;
          w_addr_reg <= a_eff;
          state_reg  <= FILL;
        end
      end
      case (state_reg)
        WAIT_SWAP: begin
          if (SWAP_ON_VSY == 0 || vsy_edge) begin
            state_reg      <= SWAP;
            disp_bank_reg  <= ~disp_bank_reg;
            disp_valid_reg <= 1'b1;
            frame_done_reg <= 1'b1;
          end
        end
        SWAP: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Writes always target the back bank, so the displayed bank is never disturbed.
  always_ff @(posedge clk) begin
    if (commit)
      mem[{~disp_bank_reg, a_eff}] <= wr_word;
    rd_data_reg <= mem[{disp_bank_reg, ram_ab}];
  end

`ifdef LCD_BB_TESTPAT_EN
  assign blank_next = ram_ab[0] ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
`else
  assign blank_next = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      blank_reg    <= '0;
    end else begin
      rd_valid_reg <= disp_valid_reg;
      blank_reg    <= blank_next;
    end
  end

  // RAM contents are never reset; rd_valid_reg masks them until the first swap.
  assign ram_db     = rd_valid_reg ? rd_data_reg : blank_reg;
  assign in_ready   = in_ready_reg;
  assign frame_done = frame_done_reg;
  assign err_sync   = err_sync_reg;

endmodule
